line_feed_ctrl: RTL

- Input-side flow controller and sequencer for the 4-line window generator.
- Gates an upstream pixel stream into the window generator and tracks line-slot occupancy, so no line is overwritten before the consumer's one-line-done interrupt frees it.
- Counts rows in and out per frame and drains the final lines at end of frame.
- Clears the datapath between frames, or on abort, with a one-cycle synchronous reset pulse.

---
 rtl/line_feed_pkg.sv | 22 ++
 rtl/line_slot_tracker.sv | 47 ++++
 rtl/line_feed_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/line_feed_pkg.sv
// rtl/line_feed_pkg.sv - shared types and default geometry for the line feed controller
package line_feed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam int DEF_IMG_WIDTH    = 256;
  localparam int DEF_IMG_HEIGHT   = 256;
  localparam int DEF_NUM_LINES    = 4;
  localparam int DEF_WINDOW_LINES = 3;

  function automatic int out_rows(input int height, input int window_lines);
    return height - window_lines + 1;
  endfunction

  localparam int OUT_ROWS = DEF_IMG_HEIGHT - DEF_WINDOW_LINES + 1;

endpackage

// File: rtl/line_slot_tracker.sv
// rtl/line_slot_tracker.sv - occupancy counter for the window generator line slots
module line_slot_tracker #(
  parameter int NUM_LINES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic rsv,
  input  logic rel,
  output logic full_nxt,
  output logic underflow
);

  localparam int SW = $clog2(NUM_LINES + 1);

  logic [SW-1:0] slots_used;
  logic [SW-1:0] slots_nxt;
  logic          empty;
  logic          rel_ok;

  assign empty     = (slots_used == '0);
  assign underflow = rel & empty;
  assign rel_ok    = rel & ~empty;

  // A reserve and a valid release in the same cycle cancel out.
  always_comb begin
    slots_nxt = slots_used;
    if (clr) begin
      slots_nxt = '0;
    end else if (rsv && !rel_ok) begin
      slots_nxt = slots_used + 1'b1;
    end else if (!rsv && rel_ok) begin
      slots_nxt = slots_used - 1'b1;
    end
  end

  assign full_nxt = (slots_nxt == SW'(NUM_LINES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_used <= '0;
    end else begin
      slots_used <= slots_nxt;
    end
  end

endmodule

// File: rtl/line_feed_ctrl.sv
// rtl/line_feed_ctrl.sv - input flow control and frame sequencing for the 4-line window generator
module line_feed_ctrl
  import line_feed_pkg::*;
#(
  parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int NUM_LINES    = DEF_NUM_LINES,
  parameter int WINDOW_LINES = DEF_WINDOW_LINES
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_start,
  input  logic                              i_abort,
  input  logic [7:0]                        i_s_data,
  input  logic                              i_s_valid,
  output logic                              o_s_ready,
  output logic [7:0]                        o_pix_data,
  output logic                              o_pix_valid,
  input  logic                              i_line_done,
  output logic                              o_dp_rst,
  output logic                              o_busy,
  output logic                              o_frame_done,
  output logic [$clog2(IMG_HEIGHT+1)-1:0]   o_rows_in,
  output logic [$clog2(IMG_HEIGHT+1)-1:0]   o_rows_out,
  output logic                              o_err
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] OUT_TOTAL = RW'(out_rows(IMG_HEIGHT, WINDOW_LINES));

  state_t        state, state_n;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] rows_in_n, rows_out_n;
  logic          err_n, ready_n, dp_rst_n, frame_done_n, busy_n;

  logic active, xfer, start_ok, abort_ok, row_last;
  logic rsv, rel_req, overrun, rel_ok, trk_clr;
  logic full_nxt, underflow;

  assign o_pix_data  = i_s_data;
  assign xfer        = i_s_valid & o_s_ready;
  assign o_pix_valid = xfer;

  assign active   = (state == FEED) || (state == DRAIN);
  assign start_ok = (state == IDLE) && i_start;
  assign abort_ok = active && i_abort;
  assign row_last = (col == COL_LAST);

  // Abort wins over every same-cycle bookkeeping event.
  assign rsv     = (state == FEED) && xfer && (col == '0) && !abort_ok;
  assign rel_req = active && i_line_done && !abort_ok && (o_rows_out != OUT_TOTAL);
  assign overrun = active && i_line_done && !abort_ok && (o_rows_out == OUT_TOTAL);
  assign rel_ok  = rel_req && !underflow;
  assign trk_clr = start_ok || (state == CLEAR);

  line_slot_tracker #(
    .NUM_LINES (NUM_LINES)
  ) u_slots (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clr       (trk_clr),
    .rsv       (rsv),
    .rel       (rel_req),
    .full_nxt  (full_nxt),
    .underflow (underflow)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (i_start) state_n = FEED;
      FEED: begin
        if (i_abort) begin
          state_n = CLEAR;
        end else if (xfer && row_last && (o_rows_in == ROW_LAST)) begin
          state_n = DRAIN;
        end
      end
      DRAIN:   if (i_abort || (o_rows_out == OUT_TOTAL)) state_n = CLEAR;
      CLEAR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    col_n        = col;
    rows_in_n    = o_rows_in;
    rows_out_n   = o_rows_out;
    err_n        = o_err;
    if (start_ok) begin
      col_n      = '0;
      rows_in_n  = '0;
      rows_out_n = '0;
      err_n      = 1'b0;
    end else begin
      if ((state == FEED) && xfer && !abort_ok) begin
        col_n = row_last ? '0 : col + 1'b1;
        if (row_last) rows_in_n = o_rows_in + 1'b1;
      end
      if (rel_ok) rows_out_n = o_rows_out + 1'b1;
      if (underflow || overrun) err_n = 1'b1;
    end
    // Outputs are registered, so they are derived from next-cycle state.
    ready_n      = (state_n == FEED) && ((col_n != '0) || !full_nxt);
    dp_rst_n     = (state_n == CLEAR);
    frame_done_n = (state == DRAIN) && (state_n == CLEAR) && !i_abort;
    busy_n       = (state_n != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col          <= '0;
      o_rows_in    <= '0;
      o_rows_out   <= '0;
      o_err        <= 1'b0;
      o_s_ready    <= 1'b0;
      o_dp_rst     <= 1'b1;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      col          <= col_n;
      o_rows_in    <= rows_in_n;
      o_rows_out   <= rows_out_n;
      o_err        <= err_n;
      o_s_ready    <= ready_n;
      o_dp_rst     <= dp_rst_n;
      o_frame_done <= frame_done_n;
      o_busy       <= busy_n;
    end
  end

endmodule
